// File: rtl/fc_pkg.sv
// Shared encodings and per-layer constants for the FC layer sequencers.
package fc_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StFetch = 3'd2,
        StDrain = 3'd3,
        StWrite = 3'd4,
        StDone  = 3'd5
    } fc_state_e;

    localparam int unsigned FC5_N_IN    = 32;
    localparam int unsigned FC5_ADDR_W  = 5;
    localparam int unsigned BRAM_RD_LAT = 1;

endpackage

// File: rtl/lat_align.sv
// One-bit shift-register delay of DEPTH cycles, with a synchronous flush.
module lat_align #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = '0;
        if (!clr_i) begin
            sr_d[0] = d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fc_layer_seq.sv
// Address/strobe sequencer for one fully-connected layer: clear, fetch N_IN
// operands, wait out read + MAC latency, then pulse result capture and done.
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int unsigned N_IN    = FC5_N_IN,
    parameter int unsigned ADDR_W  = FC5_ADDR_W,
    parameter int unsigned RD_LAT  = BRAM_RD_LAT,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] x_addr_o,
    output logic              x_en_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic              w_en_o,
    output logic              mac_clear_o,
    output logic              mac_en_o,
    output logic              mac_valid_o,
    output logic              temp_wr_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned       DRAIN_CYC  = RD_LAT + MAC_LAT;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_IN - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(DRAIN_CYC - 1);

    fc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        drain_q, drain_d;
    logic              fetch;
    logic              last;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StClear;
            end
            StClear: state_d = StFetch;
            StFetch: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = StWrite;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            StWrite: state_d = StDone;
            StDone: state_d = start_i ? StClear : StIdle;
            default: state_d = StIdle;
        endcase
        // Abort wins over everything, including a start in the same cycle.
        if (abort_i) begin
            state_d = StIdle;
            addr_d  = '0;
            drain_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    assign fetch = (state_q == StFetch);
    assign last  = fetch && (addr_q == LAST_ADDR);

    // Strobes are decoded from registered state only, so no input reaches an output.
    assign x_en_o      = fetch;
    assign w_en_o      = fetch;
    assign x_addr_o    = addr_q;
    assign w_addr_o    = addr_q;
    assign mac_clear_o = (state_q == StClear);
    assign temp_wr_o   = (state_q == StWrite);
    assign done_o      = (state_q == StDone);
    assign busy_o      = state_q inside {StClear, StFetch, StDrain, StWrite};

    lat_align #(
        .DEPTH (RD_LAT)
    ) u_en_dly (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (abort_i),
        .d_i    (fetch),
        .q_o    (mac_en_o)
    );

    lat_align #(
        .DEPTH (RD_LAT)
    ) u_valid_dly (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (abort_i),
        .d_i    (last),
        .q_o    (mac_valid_o)
    );

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench: two sequencer configurations driven with directed and random
// start/abort traffic; expected per-cycle output vectors come from frame timing rules.
module tb_fc_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n;
    logic start0, abort0, start1, abort1;

    logic [4:0] x_addr0, w_addr0;
    logic       x_en0, w_en0, clr0, men0, mval0, twr0, busy0, done0;
    logic [1:0] x_addr1, w_addr1;
    logic       x_en1, w_en1, clr1, men1, mval1, twr1, busy1, done1;

    fc_layer_seq u_dut0 (
        .clk_i       (clk),
        .rstn_i      (rst_n),
        .start_i     (start0),
        .abort_i     (abort0),
        .x_addr_o    (x_addr0),
        .x_en_o      (x_en0),
        .w_addr_o    (w_addr0),
        .w_en_o      (w_en0),
        .mac_clear_o (clr0),
        .mac_en_o    (men0),
        .mac_valid_o (mval0),
        .temp_wr_o   (twr0),
        .busy_o      (busy0),
        .done_o      (done0)
    );

    fc_layer_seq #(
        .N_IN    (4),
        .ADDR_W  (2),
        .RD_LAT  (2),
        .MAC_LAT (2)
    ) u_dut1 (
        .clk_i       (clk),
        .rstn_i      (rst_n),
        .start_i     (start1),
        .abort_i     (abort1),
        .x_addr_o    (x_addr1),
        .x_en_o      (x_en1),
        .w_addr_o    (w_addr1),
        .w_en_o      (w_en1),
        .mac_clear_o (clr1),
        .mac_en_o    (men1),
        .mac_valid_o (mval1),
        .temp_wr_o   (twr1),
        .busy_o      (busy1),
        .done_o      (done1)
    );

    typedef struct packed {
        int         cyc;
        logic       clr;
        logic       xen;
        logic       wen;
        logic [4:0] xaddr;
        logic [4:0] waddr;
        logic       men;
        logic       mval;
        logic       twr;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t exp_q[2][$];
    int   n_in_m[2]  = '{32, 4};
    int   rd_m[2]    = '{1, 2};
    int   mac_m[2]   = '{1, 2};
    int   free_at[2] = '{0, 0};
    int   n_checks   = 0;
    int   n_fail     = 0;

    function automatic int frame_len(input int d);
        return n_in_m[d] + rd_m[d] + mac_m[d] + 3;
    endfunction

    function automatic vec_t observe(input int d);
        vec_t o;
        o.cyc = cyc;
        if (d == 0) begin
            o.clr = clr0;  o.xen = x_en0;  o.wen = w_en0;
            o.xaddr = x_addr0;  o.waddr = w_addr0;
            o.men = men0;  o.mval = mval0;  o.twr = twr0;  o.done = done0;  o.busy = busy0;
        end else begin
            o.clr = clr1;  o.xen = x_en1;  o.wen = w_en1;
            o.xaddr = {3'b000, x_addr1};  o.waddr = {3'b000, w_addr1};
            o.men = men1;  o.mval = mval1;  o.twr = twr1;  o.done = done1;  o.busy = busy1;
        end
        return o;
    endfunction

    function automatic string fmt(input vec_t v);
        return $sformatf("@%0d clr=%0b xen=%0b wen=%0b xa=%0d wa=%0d men=%0b mval=%0b twr=%0b done=%0b busy=%0b",
                         v.cyc, v.clr, v.xen, v.wen, v.xaddr, v.waddr, v.men, v.mval, v.twr,
                         v.done, v.busy);
    endfunction

    // Frame whose start is sampled at the end of cycle base: frame cycle j is base+j.
    task automatic push_frame(input int d, input int base);
        int   n, rd, len;
        vec_t e;
        n   = n_in_m[d];
        rd  = rd_m[d];
        len = frame_len(d);
        for (int j = 1; j <= len; j++) begin
            e.cyc   = base + j;
            e.clr   = (j == 1);
            e.xen   = (j >= 2) && (j <= n + 1);
            e.wen   = e.xen;
            e.xaddr = e.xen ? 5'(j - 2) : 5'd0;
            e.waddr = e.xaddr;
            e.men   = (j >= rd + 2) && (j <= n + rd + 1);
            e.mval  = (j == n + rd + 1);
            e.twr   = (j == len - 1);
            e.done  = (j == len);
            e.busy  = (j < len);
            exp_q[d].push_back(e);
        end
    endtask

    task automatic drop_from(input int d, input int c);
        while (exp_q[d].size() > 0 && exp_q[d][$].cyc >= c) begin
            void'(exp_q[d].pop_back());
        end
    endtask

    // Called just after a rising edge; drives one cycle's worth of inputs.
    task automatic tick(input int d, input logic s, input logic a);
        if (d == 0) begin
            start0 = s;  abort0 = a;
        end else begin
            start1 = s;  abort1 = a;
        end
        if (a) begin
            drop_from(d, cyc + 1);
            free_at[d] = cyc + 1;
        end else if (s && cyc >= free_at[d]) begin
            push_frame(d, cyc);
            free_at[d] = cyc + frame_len(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int d, input string tag);
        vec_t o;
        o     = observe(d);
        o.cyc = 0;
        n_checks++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %s, required all outputs 0", tag, d, fmt(o));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                vec_t o, e;
                logic any;
                o   = observe(d);
                any = o.clr | o.xen | o.wen | o.men | o.mval | o.twr | o.done | o.busy
                    | (|o.xaddr) | (|o.waddr);
                if (any !== 1'b0) begin
                    n_checks++;
                    if (exp_q[d].size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output dut%0d: got %s, required idle outputs",
                                 d, fmt(o));
                    end else begin
                        e = exp_q[d].pop_front();
                        if (o !== e) begin
                            n_fail++;
                            $display("FAIL output_vector dut%0d: got %s, required %s",
                                     d, fmt(o), fmt(e));
                        end
                    end
                end else if (exp_q[d].size() > 0 && exp_q[d][0].cyc <= cyc) begin
                    n_checks++;
                    n_fail++;
                    e = exp_q[d].pop_front();
                    $display("FAIL missing_output dut%0d: got idle outputs @%0d, required %s",
                             d, cyc, fmt(e));
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;  abort0 = 1'b0;
        start1 = 1'b0;  abort1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset_state");
        check_zero(1, "reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, then a mid-frame start that must be ignored.
        tick(0, 1'b1, 1'b0);
        repeat (44) tick(0, 1'b0, 1'b0);
        tick(0, 1'b1, 1'b0);
        repeat (8) tick(0, 1'b0, 1'b0);
        tick(0, 1'b1, 1'b0);
        repeat (40) tick(0, 1'b0, 1'b0);

        // start held high: back-to-back frames with no gap.
        repeat (3 * 37) tick(0, 1'b1, 1'b0);
        repeat (40) tick(0, 1'b0, 1'b0);

        // Abort at frame cycle 20, then a clean restart.
        tick(0, 1'b1, 1'b0);
        repeat (19) tick(0, 1'b0, 1'b0);
        tick(0, 1'b0, 1'b1);
        repeat (5) tick(0, 1'b0, 1'b0);
        tick(0, 1'b1, 1'b0);
        repeat (40) tick(0, 1'b0, 1'b0);

        // Abort and start together: abort wins.
        tick(0, 1'b1, 1'b0);
        repeat (5) tick(0, 1'b0, 1'b0);
        tick(0, 1'b1, 1'b1);
        repeat (5) tick(0, 1'b0, 1'b0);

        // Asynchronous reset mid-fetch, between edges.
        tick(0, 1'b1, 1'b0);
        repeat (10) tick(0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero(0, "async_reset_drop");
        drop_from(0, cyc);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        free_at[0] = cyc;
        tick(0, 1'b1, 1'b0);
        repeat (40) tick(0, 1'b0, 1'b0);

        // Random traffic on the default configuration.
        repeat (300) tick(0, $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
        tick(0, 1'b0, 1'b0);
        repeat (45) tick(0, 1'b0, 1'b0);

        // Small configuration: single frame, held start, random traffic.
        tick(1, 1'b1, 1'b0);
        repeat (12) tick(1, 1'b0, 1'b0);
        repeat (30) tick(1, 1'b1, 1'b0);
        repeat (15) tick(1, 1'b0, 1'b0);
        repeat (200) tick(1, $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
        repeat (15) tick(1, 1'b0, 1'b0);

        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (exp_q[d].size() != 0) begin
                n_fail++;
                $display("FAIL leftover_expected dut%0d: got %0d pending, required 0",
                         d, exp_q[d].size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Sequencer for one fully-connected layer of the MNIST streamline pipeline (FC5: 32 activations × 10 output neurons).
- Streams input-activation and weight buffer addresses in lockstep, then aligns the MAC enable/valid/clear strobes to the BRAM read latency.
- Emits a result-capture pulse and a done pulse when finished.
- Sits between the top-level frame controller (start/done) and the activation buffer, weight BRAM and MAC PU of the layer.

Parameters:
- N_IN, 32, input activations per frame; also weight rows; legal range >= 2.
- ADDR_W, 5, width of the activation/weight address; must satisfy 2**ADDR_W >= N_IN.
- RD_LAT, 1, buffer read latency in cycles, from en/addr to data valid; legal range 1..3.
- MAC_LAT, 1, cycles from the last mac_en_o until the PU output is stable; legal range 1..3.

Ports:
- clk_i  in  1  system clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  frame start request; sampled in IDLE and DONE only.
- abort_i  in  1  synchronous abort; returns to IDLE from any state.
- x_addr_o  out  ADDR_W  activation buffer read address.
- x_en_o  out  1  activation buffer read enable.
- w_addr_o  out  ADDR_W  weight BRAM read address; always equals x_addr_o.
- w_en_o  out  1  weight BRAM read enable; always equals x_en_o.
- mac_clear_o  out  1  accumulator clear, one-cycle pulse.
- mac_en_o  out  1  MAC accumulate enable, aligned to read data.
- mac_valid_o  out  1  marks the final accumulate of the frame.
- temp_wr_o  out  1  one-cycle pulse: downstream captures the PU outputs.
- busy_o  out  1  high from CLEAR through WRITE.
- done_o  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset (rstn_i low, async): state=IDLE, address counter=0, enable delay line=0. Every output is 0.
- State machine: IDLE, CLEAR, FETCH, DRAIN, WRITE, DONE.
- IDLE: when start_i=1 at a clock edge, go to CLEAR.
- CLEAR: lasts 1 cycle with mac_clear_o=1, then go to FETCH.
- FETCH: lasts N_IN cycles. x_en_o=w_en_o=1; the address counts 0..N_IN-1, one step per cycle. After the last address, go to DRAIN. The address returns to 0 on leaving FETCH.
- DRAIN: lasts RD_LAT+MAC_LAT cycles, then go to WRITE.
- WRITE: lasts 1 cycle with temp_wr_o=1, then go to DONE.
- DONE: lasts 1 cycle with done_o=1 and busy_o=0. If start_i=1, go to CLEAR (back-to-back frame, no idle gap); otherwise go to IDLE.
- Enable alignment: mac_en_o is x_en_o delayed exactly RD_LAT cycles through a shift register. mac_valid_o is a "last address" flag delayed the same RD_LAT, so it is high only together with the final mac_en_o.
- Timing, cycle 1 = first cycle after start_i is sampled, default parameters:
  - mac_clear_o at cycle 1.
  - Fetch at cycles 2..33.
  - mac_en_o at cycles 3..34; mac_valid_o at cycle 34.
  - temp_wr_o at cycle 36; done_o at cycle 37.
- General latency: done_o occurs N_IN+RD_LAT+MAC_LAT+3 cycles after the start_i sample.
- start_i while busy (CLEAR..WRITE) is ignored. There is no queuing.
- abort_i=1 at any edge:
  - next state IDLE; the address counter and delay line are flushed.
  - temp_wr_o and done_o are not generated for that frame.
  - abort_i takes priority over start_i in the same cycle.
- An async reset mid-frame behaves like abort, but takes effect immediately.
- All outputs are registered (no combinational paths from inputs to outputs).

Decomposition:
- Shared package fc_pkg holds:
  - the state enum encoding (3-bit);
  - the per-layer constants FC5_N_IN=32, FC5_ADDR_W=5, BRAM_RD_LAT=1.
- One sub-module, lat_align: a parameterised 1-bit shift-register delay (DEPTH), with async active-low reset clearing to 0. It is instantiated twice, once for mac_en and once for mac_valid.

Test Plan:
- Default params, reset, then one start_i pulse:
  - mac_clear_o at cycle 1 only;
  - addresses 0..31 at cycles 2..33;
  - mac_en_o at cycles 3..34, and exactly 32 mac_en_o cycles;
  - mac_valid_o only at cycle 34;
  - temp_wr_o at cycle 36, done_o at cycle 37, busy_o low at cycle 37.
- start_i held high continuously: the second mac_clear_o occurs at cycle 38, frames repeat every 37 cycles, and there is no gap cycle.
- start_i pulsed at cycle 10 mid-frame: ignored; the timing is identical to the single-frame case.
- abort_i at cycle 20:
  - all outputs are 0 from cycle 21;
  - no temp_wr_o or done_o;
  - a start_i afterwards begins a clean frame from address 0.
- rstn_i asserted low asynchronously mid-FETCH (between edges): outputs drop to 0 immediately; after release, a start_i gives nominal timing.
- N_IN=4, RD_LAT=2, MAC_LAT=2: mac_en_o at cycles 4..7, mac_valid_o at cycle 7, temp_wr_o at cycle 10, done_o at cycle 11.
